spi_slave_sync: RTL

Parametrised SPI slave that oversamples the SPI pins in the system clock domain. It supports all four SPI modes, configurable word width and bit order, and back-to-back words within one select frame. A valid/ready interface on the system side carries receive and transmit data, with sticky overrun and underrun flags. It replaces the pin-clocked 8-bit slave in new designs and sits between the pad ring and the register or host-interface logic.

---
 rtl/spi_slave_sync.sv | 188 ++++++++++++++++++
 1 files changed

// File: rtl/spi_slave_sync.sv
// SPI slave oversampled in the clk domain: all four modes, configurable width and bit order,
// back-to-back words per frame, valid/ready data interfaces with sticky overrun/underrun flags.
module spi_slave_sync #(
    parameter int unsigned DATA_W      = 8,
    parameter bit          CPOL        = 1'b0,
    parameter bit          CPHA        = 1'b0,
    parameter bit          MSB_FIRST   = 1'b1,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              spi_sclk,
    input  logic              spi_ss_n,
    input  logic              spi_mosi,
    output logic              spi_miso,
    output logic              spi_miso_oe,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    input  logic              rx_ready,
    output logic              rx_overrun,
    output logic              tx_underrun,
    input  logic              err_clr,
    output logic              busy
);

    localparam int unsigned         CNT_W    = $clog2(DATA_W + 1);
    localparam logic [CNT_W-1:0]    LAST_BIT = CNT_W'(DATA_W - 1);

    typedef enum logic {IDLE, ACTIVE} state_t;
    state_t state, state_next;

    logic [SYNC_STAGES-1:0] sclk_sync, ss_sync, mosi_sync;
    logic                   sclk_q, ss_q;
    logic                   sclk_s, ss_s, mosi_s;
    logic                   sclk_rise, sclk_fall, lead_edge, trail_edge;
    logic                   sample_edge, shift_edge, ss_fall_det, ss_rise_det;

    logic [CNT_W-1:0]  bit_cnt;
    logic [DATA_W-1:0] rx_shift, tx_shift, hold_data;
    logic              hold_full;

    logic              sel_start, desel, sample, shift, word_done, word_start;
    logic [DATA_W-1:0] rx_word, tx_src, tx_src_rest, tx_shift_next;
    logic              tx_first, tx_out;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sclk_sync <= {SYNC_STAGES{CPOL}};
            ss_sync   <= '1;
            mosi_sync <= '0;
            sclk_q    <= CPOL;
            ss_q      <= 1'b1;
        end else begin
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], spi_sclk};
            ss_sync   <= {ss_sync[SYNC_STAGES-2:0], spi_ss_n};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], spi_mosi};
            sclk_q    <= sclk_sync[SYNC_STAGES-1];
            ss_q      <= ss_sync[SYNC_STAGES-1];
        end
    end

    assign sclk_s      = sclk_sync[SYNC_STAGES-1];
    assign ss_s        = ss_sync[SYNC_STAGES-1];
    assign mosi_s      = mosi_sync[SYNC_STAGES-1];
    assign sclk_rise   = sclk_s & ~sclk_q;
    assign sclk_fall   = ~sclk_s & sclk_q;
    assign lead_edge   = CPOL ? sclk_fall : sclk_rise;
    assign trail_edge  = CPOL ? sclk_rise : sclk_fall;
    assign sample_edge = CPHA ? trail_edge : lead_edge;
    assign shift_edge  = CPHA ? lead_edge : trail_edge;
    assign ss_fall_det = ss_q & ~ss_s;
    assign ss_rise_det = ~ss_q & ss_s;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    // With CPHA=0 the first bit is driven at word start, so the trailing edge that
    // closes the previous word (bit_cnt already back at 0) must not advance MISO.
    always_comb begin
        state_next = state;
        sel_start  = 1'b0;
        desel      = 1'b0;
        sample     = 1'b0;
        shift      = 1'b0;
        word_done  = 1'b0;
        case (state)
            IDLE: begin
                if (ss_fall_det) begin
                    state_next = ACTIVE;
                    sel_start  = 1'b1;
                end
            end
            ACTIVE: begin
                if (ss_rise_det) begin
                    state_next = IDLE;
                    desel      = 1'b1;
                end else begin
                    sample    = sample_edge;
                    shift     = shift_edge && (CPHA || (bit_cnt != '0));
                    word_done = sample_edge && (bit_cnt == LAST_BIT);
                end
            end
            default: state_next = IDLE;
        endcase
        word_start = sel_start | word_done;
    end

    always_comb begin
        rx_word       = MSB_FIRST ? {rx_shift[DATA_W-2:0], mosi_s} : {mosi_s, rx_shift[DATA_W-1:1]};
        tx_src        = hold_full ? hold_data : '0;
        tx_first      = MSB_FIRST ? tx_src[DATA_W-1] : tx_src[0];
        tx_src_rest   = MSB_FIRST ? (tx_src << 1) : (tx_src >> 1);
        tx_out        = MSB_FIRST ? tx_shift[DATA_W-1] : tx_shift[0];
        tx_shift_next = MSB_FIRST ? (tx_shift << 1) : (tx_shift >> 1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_cnt     <= '0;
            rx_shift    <= '0;
            tx_shift    <= '0;
            hold_data   <= '0;
            hold_full   <= 1'b0;
            spi_miso    <= 1'b0;
            spi_miso_oe <= 1'b0;
            rx_data     <= '0;
            rx_valid    <= 1'b0;
            rx_overrun  <= 1'b0;
            tx_underrun <= 1'b0;
        end else begin
            // A start in the same cycle as a load sees the old (empty) holding state.
            if (word_start && hold_full) begin
                hold_full <= 1'b0;
            end else if (tx_valid && !hold_full) begin
                hold_full <= 1'b1;
                hold_data <= tx_data;
            end

            tx_underrun <= (tx_underrun & ~err_clr) | (word_start & ~hold_full);
            rx_overrun  <= (rx_overrun & ~err_clr) | (word_done & rx_valid & ~rx_ready);

            if (word_done) begin
                rx_data  <= rx_word;
                rx_valid <= 1'b1;
            end else if (rx_valid && rx_ready) begin
                rx_valid <= 1'b0;
            end

            if (desel) begin
                bit_cnt     <= '0;
                rx_shift    <= '0;
                tx_shift    <= '0;
                spi_miso    <= 1'b0;
                spi_miso_oe <= 1'b0;
            end else begin
                if (sel_start) spi_miso_oe <= 1'b1;
                if (word_start) begin
                    bit_cnt  <= '0;
                    rx_shift <= '0;
                    if (!CPHA) begin
                        spi_miso <= tx_first;
                        tx_shift <= tx_src_rest;
                    end else begin
                        tx_shift <= tx_src;
                    end
                end else begin
                    if (sample) begin
                        rx_shift <= rx_word;
                        bit_cnt  <= bit_cnt + CNT_W'(1);
                    end
                    if (shift) begin
                        spi_miso <= tx_out;
                        tx_shift <= tx_shift_next;
                    end
                end
            end
        end
    end

    assign tx_ready = ~hold_full;
    assign busy     = (state == ACTIVE);

endmodule
